s3g_tx_buffered: RTL and testbench



---
 rtl/s3g_tx_buffered_if.sv | 21 ++
 rtl/s3g_tx_buffered.sv | 96 +++++++++
 tb/tb_s3g_tx_buffered.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/s3g_tx_buffered_if.sv
// s3g_tx_buffered_if: packet request, external buffer read and UART byte handshake
interface s3g_tx_buffered_if;
  logic       packet_wr;
  logic [7:0] payload_len;
  logic       busy;
  logic       packet_sent;
  logic       packet_error;
  logic [7:0] buffer_addr;
  logic [7:0] buffer_data;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  modport master (
    output packet_wr, payload_len, buffer_data, tx_done,
    input  busy, packet_sent, packet_error, buffer_addr, tx_data, tx_wr
  );
  modport slave (
    input  packet_wr, payload_len, buffer_data, tx_done,
    output busy, packet_sent, packet_error, buffer_addr, tx_data, tx_wr
  );
endinterface

// File: rtl/s3g_tx_buffered.sv
// s3g_tx_buffered: S3G framer sending D5, length, buffered payload and CRC8 over a byte handshake
module s3g_tx_buffered #(
  parameter int MAX_PAYLOAD = 32,
  parameter int TIMEOUT     = 65535
) (
  input logic clk,
  input logic rst,
  s3g_tx_buffered_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      st;
  logic [7:0]  len;
  logic [7:0]  crc;
  logic [8:0]  ph;
  logic [8:0]  nph;
  logic [31:0] cnt;
  logic        len_ok;
  logic        last;
  logic        expire;
  // Maxim/iButton CRC8, reflected poly 0x8C, one byte per call
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c;
    logic [7:0] b = d;
    logic       m;
    for (int i = 0; i < 8; i++) begin
      m = r[0] ^ b[0];
      r = r >> 1;
      b = b >> 1;
      if (m) r = r ^ 8'h8C;
    end
    return r;
  endfunction
  assign nph    = ph + 9'd1;
  assign len_ok = bus.payload_len != 8'd0 && {1'b0, bus.payload_len} <= 9'(MAX_PAYLOAD);
  assign last   = ph == {1'b0, len} + 9'd2;
  assign expire = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st               <= IDLE;
      len              <= 8'd0;
      crc              <= 8'd0;
      ph               <= 9'd0;
      cnt              <= 32'd0;
      bus.busy         <= 1'b0;
      bus.packet_sent  <= 1'b0;
      bus.packet_error <= 1'b0;
      bus.buffer_addr  <= 8'd0;
      bus.tx_data      <= 8'd0;
      bus.tx_wr        <= 1'b0;
    end else begin
      bus.tx_wr        <= 1'b0;
      bus.packet_sent  <= 1'b0;
      bus.packet_error <= 1'b0;
      case (st)
        IDLE: if (bus.packet_wr) begin
          if (len_ok) begin
            len             <= bus.payload_len;
            bus.busy        <= 1'b1;
            bus.tx_data     <= 8'hD5;
            bus.tx_wr       <= 1'b1;
            bus.buffer_addr <= 8'd0;
            crc             <= 8'd0;
            ph              <= 9'd0;
            cnt             <= 32'd0;
            st              <= WAIT;
          end else bus.packet_error <= 1'b1;
        end
        // tx_done is checked before the watchdog so a same-cycle reply still counts
        WAIT: if (bus.tx_done) st <= last ? DONE : ISSUE;
        else if (expire) begin
          bus.packet_error <= 1'b1;
          bus.busy         <= 1'b0;
          st               <= IDLE;
        end else cnt <= cnt + 32'd1;
        ISSUE: begin
          ph        <= nph;
          bus.tx_wr <= 1'b1;
          cnt       <= 32'd0;
          st        <= WAIT;
          if (nph == 9'd1) bus.tx_data <= len;
          else if (nph <= {1'b0, len} + 9'd1) begin
            bus.tx_data     <= bus.buffer_data;
            crc             <= crc8(crc, bus.buffer_data);
            bus.buffer_addr <= bus.buffer_addr + 8'd1;
          end else bus.tx_data <= crc;
        end
        DONE: begin
          bus.packet_sent <= 1'b1;
          bus.busy        <= 1'b0;
          st              <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_s3g_tx_buffered.sv
// tb_s3g_tx_buffered: directed checks of framing, CRC, rejects, watchdog, ignored inputs and async reset
module tb_s3g_tx_buffered;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  s3g_tx_buffered_if bus();
  s3g_tx_buffered #(.MAX_PAYLOAD(32), .TIMEOUT(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [0:255];
  logic [7:0] log_b [0:1023];
  logic [7:0] addr_log [0:1023];
  int wr_time [0:1023];
  logic [7:0] exp_q [$];
  int cyc = 0, wr_total = 0, addr_total = 0, sent_cnt = 0, err_cnt = 0, busy_cyc = 0, viol = 0;
  int t_last_wr = 0, t_err = 0, t_sent = 0, uart_cnt = 0, spur_ack = 0;
  int no_reply_from = 1 << 30, spur_req = 0;
  int passes = 0, total = 0, base, s0, b0, e0, a0;
  logic uart_done = 1'b0, spur = 1'b0, man_done = 1'b0, prev_wr = 1'b0;
  logic [7:0] prev_data = 8'd0, prev_addr = 8'd0;
  assign bus.tx_done = uart_done | spur | man_done;
  always @(posedge clk) bus.buffer_data <= mem[bus.buffer_addr];
  // UART responder (tx_done 5 cycles after tx_wr) and protocol monitor
  always @(negedge clk) begin
    cyc++;
    spur = 1'b0;
    if (spur_req != spur_ack && uart_done) begin
      spur = 1'b1;
      spur_ack++;
    end
    uart_done = 1'b0;
    if (rst) begin
      uart_cnt  = 0;
      prev_data = 8'd0;
      prev_addr = 8'd0;
      prev_wr   = 1'b0;
    end else begin
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_done = 1'b1;
      end
      if (bus.tx_wr) begin
        if (prev_wr) viol++;
        if (wr_total < no_reply_from) uart_cnt = 4;
        log_b[10'(wr_total)]   = bus.tx_data;
        wr_time[10'(wr_total)] = cyc;
        t_last_wr = cyc;
        wr_total++;
      end else if (bus.tx_data !== prev_data) viol++;
      if (bus.buffer_addr !== prev_addr) begin
        addr_log[10'(addr_total)] = bus.buffer_addr;
        addr_total++;
      end
      if (bus.busy) busy_cyc++;
      if (bus.packet_sent) begin
        sent_cnt++;
        t_sent = cyc;
      end
      if (bus.packet_error) begin
        err_cnt++;
        t_err = cyc;
      end
      prev_data = bus.tx_data;
      prev_addr = bus.buffer_addr;
      prev_wr   = bus.tx_wr;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic start(input logic [7:0] l);
    @(negedge clk);
    bus.payload_len = l;
    bus.packet_wr   = 1'b1;
    @(negedge clk);
    bus.packet_wr   = 1'b0;
  endtask
  task automatic finish_pkt();
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_bounded", int'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_bytes(input string tag, input int b);
    chk({tag, "_count"}, wr_total - b, exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_b%0d", tag, i), int'(log_b[10'(b + i)]), int'(exp_q[i]));
  endtask
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c = 8'd0;
    for (int i = 0; i < n; i++) begin
      c = c ^ mem[8'(i)];
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 8'h8C : c >> 1;
    end
    return c;
  endfunction
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.packet_wr   = 1'b0;
    bus.payload_len = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.busy, bus.packet_sent, bus.packet_error, bus.tx_wr, bus.tx_data, bus.buffer_addr}), 0);
    rst = 1'b0;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    base = wr_total; s0 = sent_cnt; b0 = busy_cyc;
    start(8'd3);
    finish_pkt();
    exp_q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    expect_bytes("t1", base);
    chk("t1_sent", sent_cnt - s0, 1);
    chk("t1_busy_cycles", busy_cyc - b0, 36);
    chk("t1_span", t_sent - wr_time[10'(base)], 36);
    mem[0] = 8'h3C; mem[1] = 8'h0D; mem[2] = 8'h01; mem[3] = 8'h02; mem[4] = 8'h03; mem[5] = 8'h04;
    base = wr_total; a0 = addr_total;
    start(8'd6);
    finish_pkt();
    exp_q = '{8'hD5, 8'h06, 8'h3C, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h88};
    expect_bytes("t2", base);
    chk("t2_addr_steps", addr_total - a0, 7);
    for (int i = 0; i <= 6; i++) chk($sformatf("t2_addr%0d", i), int'(addr_log[10'(a0 + i)]), i);
    mem[0] = 8'h3D; mem[1] = 8'h0D;
    base = wr_total; a0 = addr_total;
    start(8'd2);
    finish_pkt();
    exp_q = '{8'hD5, 8'h02, 8'h3D, 8'h0D, 8'h59};
    expect_bytes("t2b", base);
    chk("t2b_addr_steps", addr_total - a0, 3);
    for (int i = 0; i <= 2; i++) chk($sformatf("t2b_addr%0d", i), int'(addr_log[10'(a0 + i)]), i);
    base = wr_total; e0 = err_cnt; b0 = busy_cyc;
    start(8'd0);
    repeat (3) @(negedge clk);
    chk("t3_err_len0", err_cnt - e0, 1);
    start(8'd33);
    repeat (3) @(negedge clk);
    chk("t3_err_len33", err_cnt - e0, 2);
    chk("t3_no_tx_wr", wr_total - base, 0);
    chk("t3_busy_low", busy_cyc - b0, 0);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    base = wr_total;
    start(8'd32);
    finish_pkt();
    exp_q = '{8'hD5, 8'd32};
    for (int i = 0; i < 32; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(ref_crc(32));
    expect_bytes("t3_max", base);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    base = wr_total; e0 = err_cnt; s0 = sent_cnt;
    no_reply_from = wr_total + 1;
    start(8'd3);
    finish_pkt();
    no_reply_from = 1 << 30;
    exp_q = '{8'hD5, 8'h03};
    expect_bytes("t4", base);
    chk("t4_err", err_cnt - e0, 1);
    chk("t4_err_delay", t_err - t_last_wr, 20);
    chk("t4_no_sent", sent_cnt - s0, 0);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_late_done_wr", wr_total - base, 2);
    chk("t4_late_done_sent", sent_cnt - s0, 0);
    chk("t4_late_done_busy", int'(bus.busy), 0);
    base = wr_total;
    start(8'd3);
    finish_pkt();
    exp_q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    expect_bytes("t4_next", base);
    chk("t4_next_sent", sent_cnt - s0, 1);
    mem[0] = 8'h3D; mem[1] = 8'h0D;
    base = wr_total; s0 = sent_cnt;
    start(8'd2);
    repeat (6) @(negedge clk);
    bus.payload_len = 8'd1;
    bus.packet_wr   = 1'b1;
    spur_req++;
    @(negedge clk);
    bus.packet_wr = 1'b0;
    finish_pkt();
    repeat (20) @(negedge clk);
    exp_q = '{8'hD5, 8'h02, 8'h3D, 8'h0D, 8'h59};
    expect_bytes("t5", base);
    chk("t5_sent", sent_cnt - s0, 1);
    chk("t5_spur_fired", spur_ack, spur_req);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    base = wr_total; s0 = sent_cnt;
    start(8'd3);
    for (int n = 0; n < 200 && wr_total < base + 3; n++) @(negedge clk);
    chk("t6_reached_payload", wr_total - base, 3);
    chk("t6_busy_before", int'(bus.busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", int'({bus.busy, bus.packet_sent, bus.packet_error, bus.tx_wr, bus.tx_data, bus.buffer_addr}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_idle_after", int'({bus.busy, bus.tx_wr}), 0);
    base = wr_total;
    start(8'd3);
    finish_pkt();
    exp_q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    expect_bytes("t6", base);
    chk("t6_sent", sent_cnt - s0, 1);
    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
